// File: rtl/itch_pkg.sv
// Shared types and constants for the ITCH stream parser: message/side codes,
// order and trade enums, and the symbol table reset contents.
package itch_pkg;

    localparam int unsigned MsgWordsDef = 9;

    typedef enum logic [1:0] {
        OrdAdd     = 2'd0,
        OrdCancel  = 2'd1,
        OrdExecute = 2'd2
    } order_t;

    typedef enum logic {
        TrBuy  = 1'b0,
        TrSell = 1'b1
    } trade_t;

    localparam logic [7:0] MsgAdd     = 8'h41;
    localparam logic [7:0] MsgDelete  = 8'h44;
    localparam logic [7:0] MsgExecute = 8'h45;
    localparam logic [7:0] SideBuy    = 8'h42;
    localparam logic [7:0] SideSell   = 8'h53;

    // Symbols are space-padded ASCII with the first character in the MSB.
    localparam logic [63:0] SymAapl  = 64'h4141504C_20202020;
    localparam logic [63:0] SymAmzn  = 64'h414D5A4E_20202020;
    localparam logic [63:0] SymGoogl = 64'h474F4F47_4C202020;
    localparam logic [63:0] SymMsft  = 64'h4D534654_20202020;

    localparam int unsigned NResetSyms = 4;
    localparam logic [NResetSyms-1:0][63:0] ResetSyms = {SymMsft, SymGoogl, SymAmzn, SymAapl};

    // The wire carries the first symbol character in the lowest byte.
    function automatic logic [63:0] byte_swap64(input logic [63:0] v);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = v[56-8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_count = count_q;
    assign o_data  = mem[rd_ptr_q];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/itch_stream_parser.sv
// Streaming ITCH order parser: reassembles word streams into messages, decodes
// Add/Delete/Execute, maps stock IDs through a symbol table and buffers orders.
module itch_stream_parser
    import itch_pkg::*;
#(
    parameter int unsigned MSG_WORDS = MsgWordsDef,
    parameter int unsigned N_SYMBOLS = 4,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned ERR_W     = 16,
    localparam int unsigned SYM_W    = $clog2(N_SYMBOLS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_data,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_ready,
    input  logic             i_cfg_we,
    input  logic [SYM_W-1:0] i_cfg_idx,
    input  logic [63:0]      i_cfg_symbol,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_order_type,
    output logic             o_trade_type,
    output logic [SYM_W-1:0] o_stock_symbol,
    output logic [63:0]      o_order_id,
    output logic [31:0]      o_price,
    output logic [31:0]      o_quantity,
    output logic [47:0]      o_curr_time,
    output logic [15:0]      o_locate_code,
    output logic [15:0]      o_tracking_number,
    output logic [ERR_W-1:0] o_err_frame,
    output logic [ERR_W-1:0] o_err_type,
    output logic [ERR_W-1:0] o_err_symbol
);

    localparam int unsigned WCNT_W = $clog2(MSG_WORDS);
    localparam int unsigned CNT_W  = $clog2(OUT_DEPTH) + 1;
    localparam logic [WCNT_W-1:0] LastIdx = WCNT_W'(MSG_WORDS - 1);

    typedef enum logic [0:0] {StCollect, StDecode} state_e;

    typedef struct packed {
        order_t           order_type;
        trade_t           trade_type;
        logic [SYM_W-1:0] symbol;
        logic [63:0]      order_id;
        logic [31:0]      price;
        logic [31:0]      quantity;
        logic [47:0]      curr_time;
        logic [15:0]      locate;
        logic [15:0]      tracking;
    } order_rec_t;

    state_e                  state_q;
    logic [WCNT_W-1:0]       wcnt_q;
    logic [MSG_WORDS*32-1:0] msg_q;
    logic [63:0]             sym_q [N_SYMBOLS];
    logic [ERR_W-1:0]        err_frame_q, err_type_q, err_symbol_q;

    logic             accept, push, pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             type_ok, side_ok, sym_hit;
    logic [63:0]      stock;
    logic [SYM_W-1:0] sym_idx;
    order_rec_t       rec, fifo_rdata, out_rec;

    assign o_ready = (state_q == StCollect) && (fifo_count < CNT_W'(OUT_DEPTH));
    assign accept  = i_valid && o_ready;

    always_comb begin
        type_ok         = 1'b1;
        side_ok         = 1'b1;
        stock           = '0;
        rec             = '0;
        rec.order_type  = OrdAdd;
        rec.trade_type  = TrBuy;
        rec.order_id    = msg_q[151:88];
        rec.curr_time   = msg_q[87:40];
        rec.locate      = msg_q[23:8];
        rec.tracking    = msg_q[39:24];
        case (msg_q[7:0])
            MsgAdd: begin
                stock        = byte_swap64(msg_q[255:192]);
                rec.quantity = msg_q[191:160];
                rec.price    = msg_q[287:256];
                if (msg_q[159:152] == SideSell)     rec.trade_type = TrSell;
                else if (msg_q[159:152] != SideBuy) side_ok = 1'b0;
            end
            MsgDelete: begin
                rec.order_type = OrdCancel;
                stock          = byte_swap64(msg_q[215:152]);
            end
            MsgExecute: begin
                rec.order_type = OrdExecute;
                rec.quantity   = msg_q[183:152];
                stock          = byte_swap64(msg_q[247:184]);
            end
            default: type_ok = 1'b0;
        endcase
    end

    // Descending scan so the lowest matching index wins; empty entries never match.
    always_comb begin
        sym_hit = 1'b0;
        sym_idx = '0;
        for (int i = N_SYMBOLS - 1; i >= 0; i--) begin
            if (sym_q[i] != '0 && sym_q[i] == stock) begin
                sym_hit = 1'b1;
                sym_idx = SYM_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_SYMBOLS; i++) begin
                if (i < NResetSyms) sym_q[i] <= ResetSyms[i[1:0]];
                else                sym_q[i] <= '0;
            end
        end else if (i_cfg_we) begin
            sym_q[i_cfg_idx] <= i_cfg_symbol;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StCollect;
            wcnt_q       <= '0;
            msg_q        <= '0;
            err_frame_q  <= '0;
            err_type_q   <= '0;
            err_symbol_q <= '0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (accept) begin
                        msg_q[32*wcnt_q +: 32] <= i_data;
                        if (i_last && wcnt_q == LastIdx) begin
                            wcnt_q  <= '0;
                            state_q <= StDecode;
                        end else if (i_last || wcnt_q == LastIdx) begin
                            wcnt_q <= '0;
                            if (err_frame_q != '1) err_frame_q <= err_frame_q + 1'b1;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                StDecode: begin
                    state_q <= StCollect;
                    if (!(type_ok && side_ok)) begin
                        if (err_type_q != '1) err_type_q <= err_type_q + 1'b1;
                    end else if (!sym_hit) begin
                        if (err_symbol_q != '1) err_symbol_q <= err_symbol_q + 1'b1;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    // o_ready gated on a free slot at the last word, so this push always lands.
    assign push = (state_q == StDecode) && type_ok && side_ok && sym_hit;
    assign pop  = o_valid && i_ready;

    order_rec_t push_rec;
    always_comb begin
        push_rec        = rec;
        push_rec.symbol = sym_idx;
    end

    sync_fifo #(
        .WIDTH($bits(order_rec_t)),
        .DEPTH(OUT_DEPTH)
    ) u_out_fifo (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_push (push),
        .i_data (push_rec),
        .i_pop  (pop),
        .o_data (fifo_rdata),
        .o_empty(fifo_empty),
        .o_full (fifo_full),
        .o_count(fifo_count)
    );

    assign o_valid = !fifo_empty;
    // FIFO storage is not reset, so mask the head while nothing is buffered.
    assign out_rec = o_valid ? fifo_rdata : '0;

    assign o_order_type      = out_rec.order_type;
    assign o_trade_type      = out_rec.trade_type;
    assign o_stock_symbol    = out_rec.symbol;
    assign o_order_id        = out_rec.order_id;
    assign o_price           = out_rec.price;
    assign o_quantity        = out_rec.quantity;
    assign o_curr_time       = out_rec.curr_time;
    assign o_locate_code     = out_rec.locate;
    assign o_tracking_number = out_rec.tracking;
    assign o_err_frame       = err_frame_q;
    assign o_err_type        = err_type_q;
    assign o_err_symbol      = err_symbol_q;

endmodule

// File: tb/tb_itch_stream_parser.sv
// Directed bench for itch_stream_parser with a queue scoreboard of expected orders.
module tb_itch_stream_parser;

    localparam int MW = 9;
    localparam int NS = 4;
    localparam int OD = 4;
    localparam int EW = 16;

    logic        i_clk, i_rst_n;
    logic [31:0] i_data;
    logic        i_valid, i_last, o_ready;
    logic        i_cfg_we;
    logic [1:0]  i_cfg_idx;
    logic [63:0] i_cfg_symbol;
    logic        o_valid, i_ready;
    logic [1:0]  o_order_type;
    logic        o_trade_type;
    logic [1:0]  o_stock_symbol;
    logic [63:0] o_order_id;
    logic [31:0] o_price, o_quantity;
    logic [47:0] o_curr_time;
    logic [15:0] o_locate_code, o_tracking_number;
    logic [EW-1:0] o_err_frame, o_err_type, o_err_symbol;

    itch_stream_parser #(
        .MSG_WORDS(MW), .N_SYMBOLS(NS), .OUT_DEPTH(OD), .ERR_W(EW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
        .i_last(i_last), .o_ready(o_ready), .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx),
        .i_cfg_symbol(i_cfg_symbol), .o_valid(o_valid), .i_ready(i_ready),
        .o_order_type(o_order_type), .o_trade_type(o_trade_type),
        .o_stock_symbol(o_stock_symbol), .o_order_id(o_order_id), .o_price(o_price),
        .o_quantity(o_quantity), .o_curr_time(o_curr_time), .o_locate_code(o_locate_code),
        .o_tracking_number(o_tracking_number), .o_err_frame(o_err_frame),
        .o_err_type(o_err_type), .o_err_symbol(o_err_symbol)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  ot;
        logic        tr;
        logic [1:0]  sym;
        logic [63:0] id;
        logic [31:0] price;
        logic [31:0] qty;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [63:0] s_aapl, s_amzn, s_googl, s_msft, s_tsla, s_nvda;

    function automatic logic [15:0] loc_of(logic [63:0] id); return id[15:0] ^ 16'h1234; endfunction
    function automatic logic [15:0] trk_of(logic [63:0] id); return id[23:8] + 16'h0100; endfunction
    function automatic logic [47:0] tm_of(logic [63:0] id); return {16'h00A5, id[31:0] ^ 32'h5A5A_0F0F}; endfunction

    // First ASCII character of the symbol goes out in the lowest message byte.
    function automatic logic [63:0] wire_order(logic [63:0] s);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = s[56-8*k +: 8];
        return r;
    endfunction

    function automatic logic [287:0] mk_msg(logic [7:0] t, logic [63:0] id, logic [7:0] side,
                                            logic [31:0] qty, logic [63:0] sym, logic [31:0] price);
        logic [287:0] m;
        m = '0;
        m[7:0]    = t;
        m[23:8]   = loc_of(id);
        m[39:24]  = trk_of(id);
        m[87:40]  = tm_of(id);
        m[151:88] = id;
        if (t == 8'h44) begin
            m[215:152] = wire_order(sym);
        end else if (t == 8'h45) begin
            m[183:152] = qty;
            m[247:184] = wire_order(sym);
        end else begin
            m[159:152] = side;
            m[191:160] = qty;
            m[255:192] = wire_order(sym);
            m[287:256] = price;
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] ot, input logic tr, input logic [1:0] sym,
                            input logic [63:0] id, input logic [31:0] price, input logic [31:0] qty);
        exp_t e;
        e.ot = ot; e.tr = tr; e.sym = sym; e.id = id; e.price = price; e.qty = qty;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        i_data = d; i_valid = 1'b1; i_last = last;
        n = 0;
        while (!o_ready && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("send_ready", o_ready, 1);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic send_msg(input logic [287:0] m, input int nwords, input int last_at);
        for (int w = 0; w < nwords; w++) send_word(m[32*w +: 32], w == last_at);
    endtask

    task automatic expect_out(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!o_valid && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk({tag, "_valid"}, o_valid, 1);
        chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (o_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_type"}, o_order_type, e.ot);
            chk({tag, "_trade"}, o_trade_type, e.tr);
            chk({tag, "_sym"}, o_stock_symbol, e.sym);
            chk({tag, "_id"}, o_order_id, e.id);
            chk({tag, "_price"}, o_price, e.price);
            chk({tag, "_qty"}, o_quantity, e.qty);
            chk({tag, "_time"}, o_curr_time, tm_of(e.id));
            chk({tag, "_loc"}, o_locate_code, loc_of(e.id));
            chk({tag, "_trk"}, o_tracking_number, trk_of(e.id));
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    initial begin
        s_aapl = "AAPL    "; s_amzn = "AMZN    "; s_googl = "GOOGL   ";
        s_msft = "MSFT    "; s_tsla = "TSLA    "; s_nvda = "NVDA    ";
        i_rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
        i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_symbol = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_order_id", o_order_id, 0);
        chk("rst_err_frame", o_err_frame, 0);

        // Add AAPL, two-cycle latency with the book ready.
        i_ready = 1'b1;
        send_msg(mk_msg(8'h41, 64'd1, 8'h42, 32'd100, s_aapl, 32'h1234), 9, 8);
        push_exp(2'd0, 1'b0, 2'd0, 64'd1, 32'h1234, 32'd100);
        chk("t1_decode_valid", o_valid, 0);
        chk("t1_decode_ready", o_ready, 0);
        @(posedge i_clk); #1;
        chk("t1_latency_valid", o_valid, 1);
        expect_out("t1");
        chk("t1_popped", o_valid, 0);

        // Delete then Execute back-to-back with the book busy.
        send_msg(mk_msg(8'h44, 64'd2, 8'h00, 32'd0, s_msft, 32'd0), 9, 8);
        send_msg(mk_msg(8'h45, 64'd3, 8'h00, 32'd55, s_msft, 32'd0), 9, 8);
        push_exp(2'd1, 1'b0, 2'd3, 64'd2, 32'd0, 32'd0);
        push_exp(2'd2, 1'b0, 2'd3, 64'd3, 32'd0, 32'd55);
        @(posedge i_clk); #1;
        chk("t2_ready", o_ready, 1);
        repeat (2) @(posedge i_clk); #1;
        chk("t2_hold_type", o_order_type, 1);
        expect_out("t2_cancel");
        expect_out("t2_exec");

        // Framing errors: early last, then missing last.
        send_msg(mk_msg(8'h41, 64'd4, 8'h42, 32'd1, s_aapl, 32'd1), 6, 5);
        repeat (2) @(posedge i_clk); #1;
        chk("t3_err_frame_early", o_err_frame, 1);
        chk("t3_no_out", o_valid, 0);
        send_msg(mk_msg(8'h41, 64'd4, 8'h42, 32'd1, s_aapl, 32'd1), 9, 99);
        repeat (2) @(posedge i_clk); #1;
        chk("t3_err_frame_nolast", o_err_frame, 2);
        send_msg(mk_msg(8'h41, 64'd5, 8'h53, 32'd77, s_amzn, 32'h99), 9, 8);
        push_exp(2'd0, 1'b1, 2'd1, 64'd5, 32'h99, 32'd77);
        expect_out("t3_recover");

        // Type, side and symbol errors produce no output.
        send_msg(mk_msg(8'h5A, 64'd6, 8'h42, 32'd1, s_aapl, 32'd1), 9, 8);
        repeat (2) @(posedge i_clk); #1;
        chk("t4_err_type", o_err_type, 1);
        send_msg(mk_msg(8'h41, 64'd6, 8'h42, 32'd1, s_tsla, 32'd1), 9, 8);
        repeat (2) @(posedge i_clk); #1;
        chk("t4_err_symbol", o_err_symbol, 1);
        send_msg(mk_msg(8'h41, 64'd6, 8'h58, 32'd1, s_aapl, 32'd1), 9, 8);
        repeat (2) @(posedge i_clk); #1;
        chk("t4_err_side", o_err_type, 2);
        chk("t4_no_out", o_valid, 0);

        // Reprogram entry 3 to TSLA.
        i_cfg_we = 1'b1; i_cfg_idx = 2'd3; i_cfg_symbol = s_tsla;
        @(posedge i_clk); #1;
        i_cfg_we = 1'b0;
        send_msg(mk_msg(8'h41, 64'd7, 8'h53, 32'd300, s_tsla, 32'h4321), 9, 8);
        push_exp(2'd0, 1'b1, 2'd3, 64'd7, 32'h4321, 32'd300);
        expect_out("t5_tsla");
        send_msg(mk_msg(8'h41, 64'd8, 8'h42, 32'd1, s_msft, 32'd1), 9, 8);
        repeat (2) @(posedge i_clk); #1;
        chk("t5_msft_gone", o_err_symbol, 2);

        // A write landing on the DECODE edge must not affect that lookup.
        send_msg(mk_msg(8'h41, 64'd9, 8'h42, 32'd5, s_googl, 32'd6), 9, 8);
        i_cfg_we = 1'b1; i_cfg_idx = 2'd2; i_cfg_symbol = s_nvda;
        @(posedge i_clk); #1;
        i_cfg_we = 1'b0;
        push_exp(2'd0, 1'b0, 2'd2, 64'd9, 32'd6, 32'd5);
        expect_out("t5_coincident");
        send_msg(mk_msg(8'h41, 64'd9, 8'h42, 32'd5, s_googl, 32'd6), 9, 8);
        repeat (2) @(posedge i_clk); #1;
        chk("t5_googl_gone", o_err_symbol, 3);

        // Fill the FIFO, check back-pressure, then reset mid-message.
        for (int k = 0; k < OD; k++) begin
            send_msg(mk_msg(8'h41, 64'(10 + k), 8'h42, 32'(k + 1), s_aapl, 32'(k)), 9, 8);
            push_exp(2'd0, 1'b0, 2'd0, 64'(10 + k), 32'(k), 32'(k + 1));
        end
        @(posedge i_clk); #1;
        chk("t6_full_ready", o_ready, 0);
        expect_out("t6_pop");
        chk("t6_ready_after_pop", o_ready, 1);
        send_msg(mk_msg(8'h41, 64'd30, 8'h42, 32'd1, s_aapl, 32'd1), 3, 99);
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", o_valid, 0);
        chk("t6_rst_order_id", o_order_id, 0);
        chk("t6_rst_qty", o_quantity, 0);
        chk("t6_rst_err_type", o_err_type, 0);
        chk("t6_rst_err_symbol", o_err_symbol, 0);
        chk("t6_rst_err_frame", o_err_frame, 0);
        sb.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        chk("t6_rst_ready", o_ready, 1);
        send_msg(mk_msg(8'h41, 64'd20, 8'h53, 32'd9, s_msft, 32'd8), 9, 8);
        push_exp(2'd0, 1'b1, 2'd3, 64'd20, 32'd8, 32'd9);
        expect_out("t6_after_rst");
        chk("t6_no_frame_err", o_err_frame, 0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/itch_stream_parser.md
# itch_stream_parser

Streaming successor to the register-snapshot order parser. It accepts ITCH-style order messages as a valid/ready stream of 32-bit words and reassembles each message. It decodes Add, Delete and Execute messages and maps the 8-byte stock ID through a runtime-programmable symbol table. Decoded orders are buffered in an output FIFO that feeds the order book, so a busy book back-pressures the feed instead of dropping orders.

## Interface
Parameters:
- MSG_WORDS, 9: words per message, word 0 first, byte 0 in bits [7:0].
- N_SYMBOLS, 4: symbol table entries; SYM_W = $clog2(N_SYMBOLS).
- OUT_DEPTH, 4: output FIFO depth, power of two, ≥2.
- ERR_W, 16: width of the error counters.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_data  in  32  message word.
- i_valid  in  1  i_data valid.
- i_last  in  1  marks the final word of a message.
- o_ready  out  1  parser accepts i_data this cycle.
- i_cfg_we  in  1  symbol table write strobe.
- i_cfg_idx  in  SYM_W  table entry index.
- i_cfg_symbol  in  64  8-byte ASCII symbol, space-padded.
- o_valid  out  1  decoded order available.
- i_ready  in  1  order book accepts the order (replaces i_book_is_busy).
- o_order_type  out  2  ADD=0, CANCEL=1, EXECUTE=2.
- o_trade_type  out  1  BUY=0, SELL=1.
- o_stock_symbol  out  SYM_W  symbol table index.
- o_order_id  out  64  full order ID.
- o_price  out  32  price.
- o_quantity  out  32  share count.
- o_curr_time  out  48  timestamp.
- o_locate_code  out  16  locate code.
- o_tracking_number  out  16  tracking number.
- o_err_frame / o_err_type / o_err_symbol  out  ERR_W  saturating error counts.

## Operation
- Field map (bit offsets in the concatenated message): type [7:0]; locate [23:8]; tracking [39:24]; time [87:40]; order ID [151:88].
  - Add 'A' (0x41): side byte [159:152], qty [191:160], stock [255:192], price [287:256].
  - Delete 'D' (0x44): stock [215:152]; price, qty and side output as 0.
  - Execute 'E' (0x45): qty [183:152], stock [247:184]; price and side output as 0.
- Stock ID byte order: first byte received is the most significant byte of the 64-bit symbol compare value.
- Side byte: 'B' (0x42) maps to BUY, 'S' (0x53) maps to SELL. Any other value is a type error.
- FSM:
  - COLLECT: a word is accepted on i_valid && o_ready. The word is stored at index wcnt and wcnt increments. When the word at wcnt = MSG_WORDS-1 is accepted with i_last=1, go to DECODE.
  - Framing errors: i_last=1 with wcnt < MSG_WORDS-1, or i_last=0 at wcnt = MSG_WORDS-1. Either increments o_err_frame, discards the message, resets wcnt to 0 and stays in COLLECT.
  - DECODE (one cycle): check type, side and symbol, then push the order to the FIFO. An unknown type or bad side increments o_err_type. No table match increments o_err_symbol. A failing message is not pushed. Always return to COLLECT.
- Symbol match: lowest matching index wins. Reset table contents: AAPL, AMZN, GOOGL, MSFT (package constants), with remaining entries 0. Entry value 0 never matches.
- A cfg write lands on the clock edge. A write coincident with DECODE does not affect that DECODE; the lookup uses the pre-write table.
- o_ready = (state==COLLECT) && (fifo_count < OUT_DEPTH). Accepting the final word therefore guarantees a free slot at DECODE.
- Error counters saturate at all-ones.

## Timing
- Reset values: state COLLECT, wcnt 0, FIFO empty, all counters 0, o_valid 0. All data outputs are 0 and o_ready is 1 once reset is released.
- Final word accepted at edge N: DECODE during cycle N+1, FIFO write at edge N+1, o_valid=1 during cycle N+2 if the FIFO was empty.
- o_ready is 0 during DECODE, giving one bubble per message. Maximum throughput is one message per MSG_WORDS+1 cycles.
- Output handshake: an order is popped on o_valid && i_ready. All outputs hold stable while o_valid && !i_ready.
- Push and pop in the same cycle are allowed at any fill level. Push is blocked by construction when the FIFO is full.
- Reset asserted mid-message or with the FIFO non-empty discards all partial and buffered data immediately.

## Structure
- Package itch_pkg: order_t, trade_t, message type and side byte constants, MSG_WORDS default, reset symbol constants.
- Sub-module sync_fifo (parametrised WIDTH, DEPTH, show-ahead, exposes count) holds the packed decoded-order struct.
- The FSM, word buffer, decode logic, symbol table and counters live in the top module.

## Test plan
- Add message 'A', side 'B', qty 100, stock "AAPL    ", price 0x1234, i_ready=1 -> o_valid two cycles after the last word, type 0, symbol 0, price 0x1234, qty 100, trade 0.
- Delete followed by Execute for "MSFT    " back-to-back with i_ready=0 -> two FIFO entries and o_ready stays 1. Raising i_ready pops CANCEL then EXECUTE in order, both with price 0.
- i_last on word 5 -> o_err_frame=1 and no output. The next valid message decodes normally.
- Type byte 0x5A -> o_err_type=1. Add message for unknown stock "TSLA    " -> o_err_symbol=1. Neither produces output.
- Write "TSLA    " to index 3, then send an Add for TSLA -> o_stock_symbol=3. MSFT now gets o_err_symbol.
- Fill the FIFO to OUT_DEPTH with i_ready=0 -> o_ready=0. Pop one -> o_ready=1 next cycle. Assert reset mid-message -> all outputs return to reset values.
